// File: rtl/cpu_run_ctrl.sv
// Run controller for a test CPU: holds it in reset, lets it run until a halt
// condition or the cycle budget is hit, then freezes it and reports the outcome.
module cpu_run_ctrl #(
  parameter int         RESET_CYCLES = 4,
  parameter int         MAX_CYCLES   = 115,
  parameter int         CNT_W        = 16,
  parameter logic [4:0] HALT_REG     = 5'd31,
  parameter int         HALT_MODE    = 0,
  parameter int         LOOP_LIMIT   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             grf_we,
  input  logic [4:0]       grf_addr,
  input  logic [31:0]      grf_wdata,
  input  logic [31:0]      pc,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [31:0]      halt_value
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RST  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic       REG_HALT_EN   = (HALT_MODE == 0) || (HALT_MODE == 2);
  localparam logic       STALL_HALT_EN = (HALT_MODE == 1) || (HALT_MODE == 2);
  localparam logic [1:0] START_TARGET  = (RESET_CYCLES == 0) ? S_RUN : S_RST;

  logic [1:0]       state_q, state_d;
  logic [31:0]      rst_cnt_q, rst_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic [31:0]      prev_pc_q;
  logic             prev_valid_q;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] wr_q, wr_d;
  logic [31:0]      halt_value_q, halt_value_d;
  logic             timeout_q, timeout_d;
  logic             cpu_reset_q, running_q, done_q;

  logic             pc_same;
  logic [31:0]      stall_next;
  logic             reg_halt;
  logic             stall_halt;
  logic             budget_end;

  // prev_valid_q masks the first RUN cycle, which has no previous pc to compare.
  assign pc_same    = prev_valid_q && (pc == prev_pc_q);
  assign stall_next = !pc_same ? 32'd0 :
                      (stall_cnt_q == 32'hFFFF_FFFF) ? stall_cnt_q : stall_cnt_q + 32'd1;
  assign reg_halt   = REG_HALT_EN && grf_we && (grf_addr == HALT_REG);
  assign stall_halt = STALL_HALT_EN && pc_same && (stall_next >= 32'(LOOP_LIMIT));
  assign budget_end = (cycle_q == CNT_W'(MAX_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    cycle_d      = cycle_q;
    wr_d         = wr_q;
    halt_value_d = halt_value_q;
    timeout_d    = timeout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = START_TARGET;
          rst_cnt_d    = 32'd0;
          stall_cnt_d  = 32'd0;
          cycle_d      = '0;
          wr_d         = '0;
          halt_value_d = 32'd0;
          timeout_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_RST: begin
        if (rst_cnt_q == 32'(RESET_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        cycle_d     = cycle_q + CNT_W'(1);
        stall_cnt_d = stall_next;
        if (grf_we && (grf_addr != 5'd0) && (wr_q != '1)) begin
          wr_d = wr_q + CNT_W'(1);
        end else begin
          wr_d = wr_q;
        end
        // Priority: register halt, then stall halt, then budget exhaustion.
        if (reg_halt) begin
          state_d      = S_DONE;
          halt_value_d = grf_wdata;
          timeout_d    = 1'b0;
        end else if (stall_halt) begin
          state_d      = S_DONE;
          halt_value_d = pc;
          timeout_d    = 1'b0;
        end else if (budget_end) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= 32'd0;
      stall_cnt_q  <= 32'd0;
      prev_pc_q    <= 32'd0;
      prev_valid_q <= 1'b0;
      cycle_q      <= '0;
      wr_q         <= '0;
      halt_value_q <= 32'd0;
      timeout_q    <= 1'b0;
      cpu_reset_q  <= 1'b1;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      prev_pc_q    <= pc;
      prev_valid_q <= (state_q == S_RUN);
      cycle_q      <= cycle_d;
      wr_q         <= wr_d;
      halt_value_q <= halt_value_d;
      timeout_q    <= timeout_d;
      cpu_reset_q  <= (state_d != S_RUN);
      running_q    <= (state_d == S_RUN);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_q;
  assign wr_count    = wr_q;
  assign halt_value  = halt_value_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: three instances (halt modes 0, 1, 2) share
// one stimulus stream; expected values are hand-computed per scenario.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        grf_we;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wdata;
  logic [31:0] pc;

  logic        cpu_reset0, running0, done0, timeout0;
  logic [15:0] cycle_count0, wr_count0;
  logic [31:0] halt_value0;
  logic        cpu_reset1, running1, done1, timeout1;
  logic [15:0] cycle_count1, wr_count1;
  logic [31:0] halt_value1;
  logic        cpu_reset2, running2, done2, timeout2;
  logic [15:0] cycle_count2, wr_count2;
  logic [31:0] halt_value2;

  int n_tests;
  int n_fail;

  cpu_run_ctrl #(.HALT_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .grf_we(grf_we), .grf_addr(grf_addr),
    .grf_wdata(grf_wdata), .pc(pc), .cpu_reset(cpu_reset0), .running(running0),
    .done(done0), .timeout(timeout0), .cycle_count(cycle_count0),
    .wr_count(wr_count0), .halt_value(halt_value0)
  );

  cpu_run_ctrl #(.HALT_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .grf_we(grf_we), .grf_addr(grf_addr),
    .grf_wdata(grf_wdata), .pc(pc), .cpu_reset(cpu_reset1), .running(running1),
    .done(done1), .timeout(timeout1), .cycle_count(cycle_count1),
    .wr_count(wr_count1), .halt_value(halt_value1)
  );

  cpu_run_ctrl #(.HALT_MODE(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .grf_we(grf_we), .grf_addr(grf_addr),
    .grf_wdata(grf_wdata), .pc(pc), .cpu_reset(cpu_reset2), .running(running2),
    .done(done2), .timeout(timeout2), .cycle_count(cycle_count2),
    .wr_count(wr_count2), .halt_value(halt_value2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycle(input logic [31:0] p, input logic we, input logic [4:0] a,
                           input logic [31:0] d);
    pc        = p;
    grf_we    = we;
    grf_addr  = a;
    grf_wdata = d;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b0;
    start     = 1'b0;
    grf_we    = 1'b0;
    grf_addr  = 5'd0;
    grf_wdata = 32'd0;
    pc        = 32'd0;

    // Reset values
    do_reset();
    chk("rst_cpu_reset", {31'd0, cpu_reset0}, 32'd1);
    chk("rst_running",   {31'd0, running0},   32'd0);
    chk("rst_done",      {31'd0, done0},      32'd0);
    chk("rst_timeout",   {31'd0, timeout0},   32'd0);
    chk("rst_cycles",    {16'd0, cycle_count0}, 32'd0);

    // Start pulse: cpu_reset high for 4 cycles, then RUN
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rst_c1_cpu_reset", {31'd0, cpu_reset0}, 32'd1);
    chk("rst_c1_running",   {31'd0, running0},   32'd0);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("rst_cx_cpu_reset", {31'd0, cpu_reset0}, 32'd1);
      chk("rst_cx_running",   {31'd0, running0},   32'd0);
    end
    step();
    chk("run_c5_running",   {31'd0, running0},   32'd1);
    chk("run_c5_cpu_reset", {31'd0, cpu_reset0}, 32'd0);
    chk("run_c5_cycles",    {16'd0, cycle_count0}, 32'd0);

    // Register halt in the 10th RUN cycle; $0 write must not count
    for (int i = 1; i <= 9; i++) begin
      if (i == 2 || i == 4) run_cycle(32'h1000 + 32'(4 * i), 1'b1, 5'd5, 32'h55);
      else if (i == 3)      run_cycle(32'h1000 + 32'(4 * i), 1'b1, 5'd0, 32'h77);
      else                  run_cycle(32'h1000 + 32'(4 * i), 1'b0, 5'd0, 32'h0);
    end
    run_cycle(32'h1028, 1'b1, 5'd31, 32'h1234);
    chk("m0_done",      {31'd0, done0},      32'd1);
    chk("m0_timeout",   {31'd0, timeout0},   32'd0);
    chk("m0_running",   {31'd0, running0},   32'd0);
    chk("m0_cpu_reset", {31'd0, cpu_reset0}, 32'd1);
    chk("m0_cycles",    {16'd0, cycle_count0}, 32'd10);
    chk("m0_halt",      halt_value0,         32'h0000_1234);
    chk("m0_wr",        {16'd0, wr_count0},  32'd3);
    chk("m1_still_run", {31'd0, running1},   32'd1);
    chk("m1_cycles10",  {16'd0, cycle_count1}, 32'd10);

    // Mode 1 stall: pc held at 0x3008 for 4 cycles, $0 writes only
    for (int i = 0; i < 3; i++) run_cycle(32'h3008, 1'b1, 5'd0, 32'hDEAD);
    chk("m1_no_early_stall", {31'd0, running1}, 32'd1);
    run_cycle(32'h3008, 1'b1, 5'd0, 32'hDEAD);
    chk("m1_done",      {31'd0, done1},      32'd1);
    chk("m1_timeout",   {31'd0, timeout1},   32'd0);
    chk("m1_halt",      halt_value1,         32'h0000_3008);
    chk("m1_cycles",    {16'd0, cycle_count1}, 32'd14);
    chk("m1_wr_no_r0",  {16'd0, wr_count1},  32'd3);
    chk("m0_hold_cyc",  {16'd0, cycle_count0}, 32'd10);
    chk("m0_hold_halt", halt_value0,         32'h0000_1234);
    chk("m0_hold_done", {31'd0, done0},      32'd1);

    // Budget exhaustion vs. halt in the 115th RUN cycle
    grf_we = 1'b0;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 114; i++) run_cycle(32'h2000 + 32'(4 * i), 1'b0, 5'd0, 32'h0);
    chk("to_pre_running", {31'd0, running1}, 32'd1);
    chk("to_pre_cycles",  {16'd0, cycle_count1}, 32'd114);
    run_cycle(32'h3000, 1'b1, 5'd31, 32'h5555);
    chk("to_done",        {31'd0, done1},      32'd1);
    chk("to_timeout",     {31'd0, timeout1},   32'd1);
    chk("to_cycles",      {16'd0, cycle_count1}, 32'd115);
    chk("to_cpu_reset",   {31'd0, cpu_reset1}, 32'd1);
    chk("to_running",     {31'd0, running1},   32'd0);
    chk("to_halt_zero",   halt_value1,         32'd0);
    chk("hvt_done",       {31'd0, done0},      32'd1);
    chk("hvt_timeout",    {31'd0, timeout0},   32'd0);
    chk("hvt_cycles",     {16'd0, cycle_count0}, 32'd115);
    chk("hvt_halt",       halt_value0,         32'h0000_5555);

    // Start from DONE clears everything; start held into RST is ignored
    grf_we = 1'b0;
    start  = 1'b1;
    step();
    chk("rs_done",      {31'd0, done2},      32'd0);
    chk("rs_timeout1",  {31'd0, timeout1},   32'd0);
    chk("rs_cycles",    {16'd0, cycle_count2}, 32'd0);
    chk("rs_wr",        {16'd0, wr_count2},  32'd0);
    chk("rs_halt",      halt_value2,         32'd0);
    chk("rs_cpu_reset", {31'd0, cpu_reset2}, 32'd1);
    step();
    step();
    start = 1'b0;
    step();
    chk("rs_c4_running", {31'd0, running2}, 32'd0);
    step();
    chk("rs_c5_running", {31'd0, running2}, 32'd1);

    // Mode 2: stall and $31 write coincide -> wdata captured; mode 1 captures pc
    for (int i = 0; i < 3; i++) run_cycle(32'h4000, 1'b0, 5'd0, 32'h0);
    chk("m1b_no_first_count", {31'd0, running1}, 32'd1);
    run_cycle(32'h4000, 1'b1, 5'd31, 32'hCAFE);
    chk("m2_done",    {31'd0, done2},      32'd1);
    chk("m2_timeout", {31'd0, timeout2},   32'd0);
    chk("m2_halt",    halt_value2,         32'h0000_CAFE);
    chk("m2_cycles",  {16'd0, cycle_count2}, 32'd4);
    chk("m1b_halt",   halt_value1,         32'h0000_4000);
    chk("m1b_cycles", {16'd0, cycle_count1}, 32'd4);

    // Reset mid-RUN aborts without DONE
    grf_we = 1'b0;
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 3; i++) run_cycle(32'h6000 + 32'(4 * i), 1'b1, 5'd7, 32'h1);
    chk("ab_pre_wr", {16'd0, wr_count0}, 32'd3);
    grf_we = 1'b0;
    reset  = 1'b1;
    step();
    reset = 1'b0;
    chk("ab_cpu_reset", {31'd0, cpu_reset0}, 32'd1);
    chk("ab_running",   {31'd0, running0},   32'd0);
    chk("ab_done",      {31'd0, done0},      32'd0);
    chk("ab_timeout",   {31'd0, timeout0},   32'd0);
    chk("ab_cycles",    {16'd0, cycle_count0}, 32'd0);
    chk("ab_wr",        {16'd0, wr_count0},  32'd0);
    chk("ab_halt",      halt_value0,         32'd0);
    step();
    step();
    chk("ab_idle_done",    {31'd0, done0},    32'd0);
    chk("ab_idle_running", {31'd0, running0}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
